// File: rtl/exc_pkg.sv
// exc_pkg -- shared definitions for the exception commit sequencer.
//   * ExcCode values written to CP0 Cause.ExcCode (and the M-stage type codes
//     that map onto them; type 1 is the interrupt marker, committed as ExcCode 0)
//   * sequencer state encoding
//   * default exception vector (BEV=1 general exception entry)
package exc_pkg;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C,
        EXC_ERET = 5'h0E
    } exc_code_t;

    // M-stage type encoding for an interrupt (differs from its ExcCode).
    localparam logic [4:0] TYPE_INT = 5'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } exc_state_t;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_flush_timer.sv
// exc_flush_timer -- loadable down-counter with a zero flag.
// Used by exc_commit_seq for the post-commit flush length and, when the
// drain watchdog is built in, for the bus-drain timeout.
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset (count -> 0)
//   load      load load_val this cycle (takes priority over en)
//   load_val  value to load
//   en        decrement by one while nonzero
//   done      count == 0
module exc_flush_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/exc_commit_seq.sv
// exc_commit_seq -- precise exception / ERET commit sequencer for the
// 5-stage MIPS pipeline.
//
// Flow: IDLE latches the M-stage exception, DRAIN waits for the data bus to
// go quiet, COMMIT (one cycle) pulses the CP0 update and the fetch redirect,
// FLUSH keeps flush_o high for FLUSH_CYCLES more cycles while ignoring the
// (now flushed) M-stage exception input.
//
// Optional build macro: EXC_TIMEOUT_EN -- adds a DRAIN watchdog
// (TIMEOUT_CYCLES) that forces COMMIT and raises sticky drain_timeout_o.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   excepttype_i         M-stage exception type (0 = none, 0xE = eret)
//   pc_i, bad_addr_i     M-stage PC and faulting address
//   in_delay_slot_i      M-stage instruction sits in a delay slot
//   epc_i                current CP0 EPC (ERET target)
//   mem_busy_i           data-bus request outstanding
//   stall_o, flush_o     pipeline freeze / flush F-D-E-M
//   redirect_valid_o/pc  one-cycle fetch redirect
//   cp0_exc_we_o ...     CP0 Cause/EPC/Status.EXL write strobe and data
//   cp0_badv_we_o/badv   BadVAddr write strobe and data
//   cp0_eret_we_o        clear Status.EXL
//   busy_o               sequencer not idle
//   drain_timeout_o      (EXC_TIMEOUT_EN only) sticky watchdog flag
module exc_commit_seq
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES   = 2
`ifdef EXC_TIMEOUT_EN
   ,parameter int          TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] bad_addr_i,
    input  logic        in_delay_slot_i,
    input  logic [31:0] epc_i,
    input  logic        mem_busy_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        cp0_exc_we_o,
    output logic [4:0]  cp0_exc_code_o,
    output logic        cp0_bd_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_badv_we_o,
    output logic [31:0] cp0_badv_o,
    output logic        cp0_eret_we_o,
`ifdef EXC_TIMEOUT_EN
    output logic        drain_timeout_o,
`endif
    output logic        busy_o
);

    exc_state_t  state_reg, state_next;
    logic [4:0]  type_reg;
    logic [31:0] pc_reg;
    logic [31:0] badaddr_reg;
    logic        bd_reg;

    logic exc_seen;
    logic flush_done;

    assign exc_seen = (excepttype_i != 32'd0);

    // ---------------- flush length counter ----------------
    // Loaded with FLUSH_CYCLES-1 while in COMMIT so FLUSH lasts exactly
    // FLUSH_CYCLES cycles (exits on the cycle the count is already zero).
    exc_flush_timer #(.WIDTH(4)) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg == ST_COMMIT),
        .load_val (4'(FLUSH_CYCLES - 1)),
        .en       (state_reg == ST_FLUSH),
        .done     (flush_done)
    );

`ifdef EXC_TIMEOUT_EN
    // ---------------- drain watchdog ----------------
    // Loaded on entry to DRAIN; reaching zero with the bus still busy means
    // TIMEOUT_CYCLES DRAIN cycles have elapsed.
    logic wd_done;
    logic wd_fire;
    logic drain_timeout_reg;

    exc_flush_timer #(.WIDTH(8)) u_drain_wd (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_reg == ST_IDLE) && exc_seen && mem_busy_i),
        .load_val (8'(TIMEOUT_CYCLES - 1)),
        .en       (state_reg == ST_DRAIN),
        .done     (wd_done)
    );

    assign wd_fire = (state_reg == ST_DRAIN) && mem_busy_i && wd_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_timeout_reg <= 1'b0;
        end else if (wd_fire) begin
            drain_timeout_reg <= 1'b1;
        end
    end

    assign drain_timeout_o = drain_timeout_reg;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Exception context captured only when leaving IDLE; later M-stage
    // activity cannot be older than the one already held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_reg    <= '0;
            pc_reg      <= '0;
            badaddr_reg <= '0;
            bd_reg      <= 1'b0;
        end else if ((state_reg == ST_IDLE) && exc_seen) begin
            type_reg    <= excepttype_i[4:0];
            pc_reg      <= pc_i;
            badaddr_reg <= bad_addr_i;
            bd_reg      <= in_delay_slot_i;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (exc_seen) begin
                    state_next = mem_busy_i ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy_i) begin
                    state_next = ST_COMMIT;
                end
`ifdef EXC_TIMEOUT_EN
                else if (wd_fire) begin
                    state_next = ST_COMMIT;
                end
`endif
            end
            ST_COMMIT: begin
                state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        cp0_exc_we_o     = 1'b0;
        cp0_exc_code_o   = 5'd0;
        cp0_bd_o         = 1'b0;
        cp0_epc_o        = 32'd0;
        cp0_badv_we_o    = 1'b0;
        cp0_badv_o       = 32'd0;
        cp0_eret_we_o    = 1'b0;
        busy_o           = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                // Same-cycle freeze; gated by rst so every output reads 0
                // while reset is held even if the M stage still shows a type.
                stall_o = rst && exc_seen;
            end
            ST_DRAIN: begin
                stall_o = 1'b1;
            end
            ST_COMMIT: begin
                stall_o          = 1'b1;
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                if (type_reg == EXC_ERET) begin
                    redirect_pc_o = epc_i;
                    cp0_eret_we_o = 1'b1;
                end else begin
                    redirect_pc_o  = EXC_VECTOR;
                    cp0_exc_we_o   = 1'b1;
                    cp0_exc_code_o = (type_reg == TYPE_INT) ? EXC_INT : type_reg;
                    cp0_bd_o       = bd_reg;
                    // A delay-slot fault restarts at the branch.
                    cp0_epc_o      = bd_reg ? (pc_reg - 32'd4) : pc_reg;
                    if ((type_reg == EXC_ADEL) || (type_reg == EXC_ADES)) begin
                        cp0_badv_we_o = 1'b1;
                        cp0_badv_o    = badaddr_reg;
                    end
                end
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_commit_seq.sv
// tb_exc_commit_seq -- directed self-checking bench for exc_commit_seq.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Build with +define+EXC_TIMEOUT_EN to add the watchdog scenario
// (DUT built with TIMEOUT_CYCLES=4).
module tb_exc_commit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype;
    logic [31:0] pc;
    logic [31:0] bad_addr;
    logic        in_delay_slot;
    logic [31:0] epc;
    logic        mem_busy;
    logic        stall, flush, redirect_valid, cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret_we, busy;
    logic [31:0] redirect_pc, cp0_epc, cp0_badv;
    logic [4:0]  cp0_exc_code;
`ifdef EXC_TIMEOUT_EN
    logic        drain_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef EXC_TIMEOUT_EN
    exc_commit_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .excepttype_i(excepttype), .pc_i(pc),
        .bad_addr_i(bad_addr), .in_delay_slot_i(in_delay_slot), .epc_i(epc),
        .mem_busy_i(mem_busy), .stall_o(stall), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .cp0_exc_we_o(cp0_exc_we), .cp0_exc_code_o(cp0_exc_code), .cp0_bd_o(cp0_bd),
        .cp0_epc_o(cp0_epc), .cp0_badv_we_o(cp0_badv_we), .cp0_badv_o(cp0_badv),
        .cp0_eret_we_o(cp0_eret_we), .drain_timeout_o(drain_timeout), .busy_o(busy)
    );
`else
    exc_commit_seq dut (
        .clk(clk), .rst(rst), .excepttype_i(excepttype), .pc_i(pc),
        .bad_addr_i(bad_addr), .in_delay_slot_i(in_delay_slot), .epc_i(epc),
        .mem_busy_i(mem_busy), .stall_o(stall), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .cp0_exc_we_o(cp0_exc_we), .cp0_exc_code_o(cp0_exc_code), .cp0_bd_o(cp0_bd),
        .cp0_epc_o(cp0_epc), .cp0_badv_we_o(cp0_badv_we), .cp0_badv_o(cp0_badv),
        .cp0_eret_we_o(cp0_eret_we), .busy_o(busy)
    );
`endif

    // {stall, flush, rv, rpc, exc_we, code, bd, epc, badv_we, badv, eret_we, busy}
    logic [108:0] obs;
    assign obs = {stall, flush, redirect_valid, redirect_pc, cp0_exc_we, cp0_exc_code,
                  cp0_bd, cp0_epc, cp0_badv_we, cp0_badv, cp0_eret_we, busy};

    function automatic logic [108:0] ev(
        input logic s, input logic f, input logic rv, input logic [31:0] rpc,
        input logic xwe, input logic [4:0] code, input logic bd_e, input logic [31:0] epc_e,
        input logic bwe, input logic [31:0] bv, input logic ewe, input logic bsy);
        return {s, f, rv, rpc, xwe, code, bd_e, epc_e, bwe, bv, ewe, bsy};
    endfunction

    task automatic chk(input string tag, input logic [108:0] o, input logic [108:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    logic [108:0] ZERO, IDLE_STALL, DRAINV, FLUSHV;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        ZERO       = '0;
        IDLE_STALL = ev(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        DRAINV     = ev(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        FLUSHV     = ev(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        rst = 1'b0; excepttype = 32'h0; pc = 32'h0; bad_addr = 32'h0;
        in_delay_slot = 1'b0; epc = 32'h0; mem_busy = 1'b0;
        #2 chk("reset_state", obs, ZERO);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1 chk("post_reset_idle", obs, ZERO);

        // ---- syscall, idle bus ----
        @(negedge clk); excepttype = 32'h8; pc = 32'h8000_1000; in_delay_slot = 1'b0;
        #1 chk("sys_idle_stall", obs, IDLE_STALL);
        @(negedge clk); excepttype = 32'h0;
        #1 chk("sys_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 5'h08, 1'b0,
                                     32'h8000_1000, 1'b0, 32'h0, 1'b0, 1'b1));
        @(negedge clk); #1 chk("sys_flush1", obs, FLUSHV);
        @(negedge clk); #1 chk("sys_flush2", obs, FLUSHV);
        @(negedge clk); #1 chk("sys_idle_after", obs, ZERO);
        $display("txn syscall pc=80001000 done");

        // ---- AdEL in delay slot ----
        @(negedge clk); excepttype = 32'h4; pc = 32'h8000_2004; bad_addr = 32'h8000_2006; in_delay_slot = 1'b1;
        #1 chk("adel_idle_stall", obs, IDLE_STALL);
        @(negedge clk); excepttype = 32'h0; in_delay_slot = 1'b0;
        #1 chk("adel_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 5'h04, 1'b1,
                                      32'h8000_2000, 1'b1, 32'h8000_2006, 1'b0, 1'b1));
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 chk("adel_idle_after", obs, ZERO);
        $display("txn adel bd=1 pc=80002004 done");

        // ---- overflow with bus busy for 5 cycles ----
        @(negedge clk); excepttype = 32'hC; pc = 32'h8000_3000; bad_addr = 32'h1234_5678; mem_busy = 1'b1;
        #1 chk("ov_idle_stall", obs, IDLE_STALL);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1 chk("ov_drain_busy", obs, DRAINV);
        end
        @(negedge clk); mem_busy = 1'b0;
        #1 chk("ov_drain_release", obs, DRAINV);
        @(negedge clk); excepttype = 32'h0;
        #1 chk("ov_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 5'h0C, 1'b0,
                                    32'h8000_3000, 1'b0, 32'h0, 1'b0, 1'b1));
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 chk("ov_idle_after", obs, ZERO);
        $display("txn overflow with drain done");

        // ---- ERET ----
        @(negedge clk); excepttype = 32'hE; pc = 32'h8000_4000; epc = 32'h8000_0100;
        #1 chk("eret_idle_stall", obs, IDLE_STALL);
        @(negedge clk); excepttype = 32'h0;
        #1 chk("eret_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 5'h0, 1'b0,
                                      32'h0, 1'b0, 32'h0, 1'b1, 1'b1));
        @(negedge clk); #1 chk("eret_flush1", obs, FLUSHV);
        @(negedge clk); @(negedge clk);
        #1 chk("eret_idle_after", obs, ZERO);
        $display("txn eret epc=80000100 done");

        // ---- breakpoint held during FLUSH: no re-trigger ----
        @(negedge clk); excepttype = 32'h9; pc = 32'h8000_5000; in_delay_slot = 1'b1;
        #1 chk("bp_idle_stall", obs, IDLE_STALL);
        @(negedge clk);
        #1 chk("bp_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 5'h09, 1'b1,
                                    32'h8000_4FFC, 1'b0, 32'h0, 1'b0, 1'b1));
        @(negedge clk); #1 chk("bp_flush1_held", obs, FLUSHV);
        @(negedge clk); #1 chk("bp_flush2_held", obs, FLUSHV);
        @(negedge clk); excepttype = 32'h0; in_delay_slot = 1'b0;
        #1 chk("bp_no_retrigger", obs, ZERO);
        $display("txn bp held through flush done");

        // ---- reset during DRAIN ----
        @(negedge clk); excepttype = 32'hA; pc = 32'h8000_6000; mem_busy = 1'b1;
        #1 chk("ri_idle_stall", obs, IDLE_STALL);
        @(negedge clk); #1 chk("ri_drain", obs, DRAINV);
        #1 rst = 1'b0;
        #1 chk("ri_reset_async", obs, ZERO);
        @(negedge clk); @(negedge clk);
        rst = 1'b1; excepttype = 32'h0; mem_busy = 1'b0;
        #1 chk("ri_release", obs, ZERO);
        @(negedge clk); #1 chk("ri_no_strobe1", obs, ZERO);
        @(negedge clk); #1 chk("ri_no_strobe2", obs, ZERO);
        $display("txn reset during drain done");

`ifdef EXC_TIMEOUT_EN
        // ---- watchdog: bus stuck busy ----
        chk("wd_flag_clear", {108'h0, drain_timeout}, 109'h0);
        @(negedge clk); excepttype = 32'h5; pc = 32'h8000_7000; bad_addr = 32'h8000_7001; mem_busy = 1'b1;
        #1 chk("wd_idle_stall", obs, IDLE_STALL);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1 chk("wd_drain", obs, DRAINV);
        end
        @(negedge clk); excepttype = 32'h0;
        #1 chk("wd_commit", obs, ev(1'b1, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 5'h05, 1'b0,
                                    32'h8000_7000, 1'b1, 32'h8000_7001, 1'b0, 1'b1));
        chk("wd_flag_set", {108'h0, drain_timeout}, 109'h1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 chk("wd_idle_after", obs, ZERO);
        chk("wd_flag_sticky", {108'h0, drain_timeout}, 109'h1);
        rst = 1'b0;
        #1 chk("wd_flag_reset", {108'h0, drain_timeout}, 109'h0);
        @(negedge clk); rst = 1'b1; mem_busy = 1'b0;
        $display("txn drain watchdog done");
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
